// File: rtl/simd_cout_lane_split.sv
// Multi-cycle SIMD adder/subtractor: resolves one SLICE_W slice per cycle and either
// forwards each slice carry to the next slice or emits it as a lane carry-out.
module simd_cout_lane_split #(
   parameter int SLICE_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           mode,
   input  logic                 sub,
   input  logic                 cin,
   input  logic [4*SLICE_W-1:0] a,
   input  logic [4*SLICE_W-1:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*SLICE_W-1:0] sum,
   output logic [3:0]           cout
);

   localparam int W = 4 * SLICE_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [W-1:0]         a_r;
   logic [W-1:0]         b_r;
   logic [1:0]           mode_r;
   logic                 lane_cin_r;
   logic                 carry_r;
   logic [1:0]           k_r;
   logic [W-1:0]         sum_r;
   logic [3:0]           cout_r;
   logic [SLICE_W-1:0]   slice_a_s;
   logic [SLICE_W-1:0]   slice_b_s;
   logic                 carry_in_s;
   logic                 top_s;
   logic [SLICE_W:0]     slice_res_s;

   function automatic logic lane_start(input logic [1:0] m, input logic [1:0] k);
      logic r;
      case (m)
         2'd0:    r = (k == 2'd0);
         2'd1:    r = (k[0] == 1'b0);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic lane_top(input logic [1:0] m, input logic [1:0] k);
      logic r;
      case (m)
         2'd0:    r = (k == 2'd3);
         2'd1:    r = (k[0] == 1'b1);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);
   assign sum       = sum_r;
   assign cout      = cout_r;

   // Current slice add: a lane's first slice takes the lane carry-in, others the forwarded carry.
   always_comb begin
      slice_a_s   = a_r[k_r*SLICE_W +: SLICE_W];
      slice_b_s   = b_r[k_r*SLICE_W +: SLICE_W];
      top_s       = lane_top(mode_r, k_r);
      carry_in_s  = lane_start(mode_r, k_r) ? lane_cin_r : carry_r;
      slice_res_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{SLICE_W{1'b0}}, carry_in_s};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) state_s = RUN;
            else          state_s = IDLE;
         end
         RUN: begin
            if (k_r == 2'd3) state_s = DONE;
            else             state_s = RUN;
         end
         DONE: begin
            if (out_ready) state_s = IDLE;
            else           state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // Operand capture and per-slice result write-back; subtract pre-inverts b and forces carry-in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r        <= {W{1'b0}};
         b_r        <= {W{1'b0}};
         mode_r     <= 2'd0;
         lane_cin_r <= 1'b0;
         carry_r    <= 1'b0;
         k_r        <= 2'd0;
         sum_r      <= {W{1'b0}};
         cout_r     <= 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r        <= a;
                  b_r        <= b ^ {W{sub}};
                  mode_r     <= mode;
                  lane_cin_r <= sub | cin;
                  carry_r    <= 1'b0;
                  k_r        <= 2'd0;
                  sum_r      <= {W{1'b0}};
                  cout_r     <= 4'd0;
               end
            end
            RUN: begin
               sum_r[k_r*SLICE_W +: SLICE_W] <= slice_res_s[SLICE_W-1:0];
               cout_r[k_r] <= top_s ? slice_res_s[SLICE_W] : 1'b0;
               carry_r     <= top_s ? 1'b0 : slice_res_s[SLICE_W];
               k_r         <= k_r + 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simd_cout_lane_split.sv
// Self-checking bench for simd_cout_lane_split: directed cases, backpressure, mid-run reset,
// and randomized operations against a per-lane arithmetic reference model.
module tb_simd_cout_lane_split;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  mode;
   logic        sub;
   logic        cin;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic [3:0]  cout;

   int checks = 0;
   int errors = 0;

   simd_cout_lane_split #(.SLICE_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sub(sub), .cin(cin), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   // Reference: each lane is an independent lw-bit add (or a + ~b + 1), carry out of the lane top.
   function automatic void model(input logic [1:0] m, input logic s, input logic c,
                                 input logic [31:0] oa, input logic [31:0] ob,
                                 output logic [31:0] es, output logic [3:0] ec);
      int lw;
      int nl;
      longint unsigned mask;
      longint unsigned av;
      longint unsigned bv;
      longint unsigned r;
      lw = (m == 2'd0) ? 32 : (m == 2'd1) ? 16 : 8;
      nl = 32 / lw;
      mask = (64'd1 << lw) - 64'd1;
      es = 32'd0;
      ec = 4'd0;
      for (int l = 0; l < nl; l++) begin
         av = (longint'(oa) >> (l * lw)) & mask;
         bv = (longint'(ob) >> (l * lw)) & mask;
         if (s) r = av + ((~bv) & mask) + 64'd1;
         else   r = av + bv + longint'(c);
         es = es | 32'((r & mask) << (l * lw));
         ec[(l + 1) * (lw / 8) - 1] = r[lw];
      end
   endfunction

   task automatic issue(input logic [31:0] oa, input logic [31:0] ob, input logic [1:0] om,
                        input logic os, input logic oc);
      int guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready got %b want 1", in_ready);
      end
      a = oa; b = ob; mode = om; sub = os; cin = oc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mode = 2'd0; sub = 1'b0; cin = 1'b0; a = 32'd0; b = 32'd0;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'd0 || cout !== 4'd0) begin
         errors++;
         $display("FAIL reset got rdy=%b ov=%b sum=%h cout=%b want 1 0 0 0",
                  in_ready, out_valid, sum, cout);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [31:0] ta[4]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0001FFFF, 32'h05050505};
      logic [31:0] tb_[4]  = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h06040506};
      logic [1:0]  tm[4]   = '{2'd0, 2'd2, 2'd1, 2'd2};
      logic        ts[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic        tc[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] es[4]   = '{32'h00000000, 32'hFFFFFF00, 32'h00010000, 32'hFF0100FF};
      logic [3:0]  ec[4]   = '{4'b1000, 4'b0001, 4'b0010, 4'b0110};
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue(ta[i], tb_[i], tm[i], ts[i], tc[i]);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL directed%0d_busy in_ready=%b want 0", i, in_ready);
         end
         wait_done(lat);
         checks++;
         if (lat !== 4) begin
            errors++;
            $display("FAIL directed%0d_latency got %0d want 4", i, lat);
         end
         checks++;
         if (sum !== es[i] || cout !== ec[i]) begin
            errors++;
            $display("FAIL directed%0d_result got sum=%h cout=%b want sum=%h cout=%b",
                     i, sum, cout, es[i], ec[i]);
         end
         release_result();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      issue(32'hFFFFFFFF, 32'h00000001, 2'd0, 1'b0, 1'b0);
      wait_done(lat);
      for (int i = 0; i < 3; i++) begin
         a = $urandom; b = $urandom; mode = 2'd2; in_valid = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h00000000 || cout !== 4'b1000) begin
            errors++;
            $display("FAIL backpressure%0d got ov=%b rdy=%b sum=%h cout=%b want 1 0 00000000 1000",
                     i, out_valid, in_ready, sum, cout);
         end
      end
      in_valid = 1'b0;
      release_result();
      checks++;
      if (sum !== 32'h00000000 || cout !== 4'b1000) begin
         errors++;
         $display("FAIL idle_hold got sum=%h cout=%b want 00000000 1000", sum, cout);
      end
   endtask

   task automatic test_reset_midrun();
      int lat;
      issue(32'h0001FFFF, 32'h00000001, 2'd1, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 4'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrun_reset got ov=%b sum=%h cout=%b rdy=%b want 0 0 0 1",
                  out_valid, sum, cout, in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(32'hFFFFFFFF, 32'h00000001, 2'd2, 1'b0, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 4 || sum !== 32'hFFFFFF00 || cout !== 4'b0001) begin
         errors++;
         $display("FAIL after_reset got lat=%0d sum=%h cout=%b want 4 FFFFFF00 0001", lat, sum, cout);
      end
      release_result();
   endtask

   task automatic test_random();
      logic [31:0] oa, ob, es;
      logic [1:0]  om;
      logic        os, oc;
      logic [3:0]  ec;
      int lat;
      for (int i = 0; i < 40; i++) begin
         oa = $urandom; ob = $urandom; om = 2'($urandom_range(0, 3));
         os = 1'($urandom_range(0, 1)); oc = 1'($urandom_range(0, 1));
         if (i % 5 == 0) ob = ~oa;
         model(om, os, oc, oa, ob, es, ec);
         issue(oa, ob, om, os, oc);
         a = $urandom; b = $urandom; mode = 2'($urandom_range(0, 3));
         sub = ~os; cin = ~oc;
         wait_done(lat);
         checks++;
         if (lat !== 4 || sum !== es || cout !== ec) begin
            errors++;
            $display("FAIL random%0d m=%0d s=%b c=%b a=%h b=%h got lat=%0d sum=%h cout=%b want 4 %h %b",
                     i, om, os, oc, oa, ob, lat, sum, cout, es, ec);
         end
         release_result();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] oa, ob, es;
      logic [3:0]  ec;
      int lat;
      for (int i = 0; i < 4; i++) begin
         oa = $urandom; ob = $urandom;
         model(2'(i), 1'b0, 1'b1, oa, ob, es, ec);
         a = oa; b = ob; mode = 2'(i); sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         wait_done(lat);
         checks++;
         if (lat !== 4 || sum !== es || cout !== ec) begin
            errors++;
            $display("FAIL b2b%0d got lat=%0d sum=%h cout=%b want 4 %h %b", i, lat, sum, cout, es, ec);
         end
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midrun();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
